// File: rtl/block_move_controller_pkg.sv
// Shared definitions for the sliding-block move controller: word fields, FSM states, op codes.
package block_move_controller_pkg;

  localparam int ORIENT_BIT = 0;
  localparam int X_LSB      = 1;
  localparam int X_MSB      = 8;
  localparam int Y_LSB      = 9;
  localparam int Y_MSB      = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_ORIENT = 3'd0,
    OP_LEFT   = 3'd1,
    OP_RIGHT  = 3'd2,
    OP_UP     = 3'd3,
    OP_DOWN   = 3'd4
  } op_e;

  function automatic logic [7:0] word_x(input logic [15:0] w);
    return w[X_MSB:X_LSB];
  endfunction

  function automatic logic [6:0] word_y(input logic [15:0] w);
    return w[Y_MSB:Y_LSB];
  endfunction

endpackage

// File: rtl/block_move_controller_rect_overlap.sv
// Combinational rectangle-overlap test between two block words; touching edges do not count.
module block_move_controller_rect_overlap
  import block_move_controller_pkg::*;
#(
  parameter int BLK_LEN = 16,
  parameter int BLK_THK = 8
) (
  input  logic [15:0] a_word_i,
  input  logic [15:0] b_word_i,
  output logic        overlap_o
);

  logic [8:0] ax_s, ay_s, aw_s, ah_s;
  logic [8:0] bx_s, by_s, bw_s, bh_s;

  assign ax_s = {1'b0, word_x(a_word_i)};
  assign ay_s = {2'b00, word_y(a_word_i)};
  assign bx_s = {1'b0, word_x(b_word_i)};
  assign by_s = {2'b00, word_y(b_word_i)};

  // Vertical blocks swap their long and short extents.
  assign aw_s = a_word_i[ORIENT_BIT] ? 9'(BLK_THK) : 9'(BLK_LEN);
  assign ah_s = a_word_i[ORIENT_BIT] ? 9'(BLK_LEN) : 9'(BLK_THK);
  assign bw_s = b_word_i[ORIENT_BIT] ? 9'(BLK_THK) : 9'(BLK_LEN);
  assign bh_s = b_word_i[ORIENT_BIT] ? 9'(BLK_LEN) : 9'(BLK_THK);

  assign overlap_o = (ax_s < bx_s + bw_s) && (bx_s < ax_s + aw_s) &&
                     (ay_s < by_s + bh_s) && (by_s < ay_s + ah_s);

endmodule

// File: rtl/block_move_controller.sv
// Block register file plus the IDLE/CALC/CHECK/DONE sequencer that validates and commits edits.
module block_move_controller
  import block_move_controller_pkg::*;
#(
  parameter int          NUM_BLOCKS = 4,
  parameter int          X_MAX      = 159,
  parameter int          Y_MAX      = 119,
  parameter int          BLK_LEN    = 16,
  parameter int          BLK_THK    = 8,
  parameter int          STEP       = 1,
  parameter logic [15:0] INIT0      = 16'h2814,
  parameter logic [15:0] INIT1      = 16'h5051,
  parameter logic [15:0] INIT2      = 16'h78A0,
  parameter logic [15:0] INIT3      = 16'hB4F1
) (
  input  logic        clock_i,
  input  logic        resetn_i,
  input  logic [1:0]  sel_i,
  input  logic        orient_in_i,
  input  logic        set_orient_i,
  input  logic        move_left_i,
  input  logic        move_right_i,
  input  logic        move_up_i,
  input  logic        move_down_i,
  output logic [15:0] block0_o,
  output logic [15:0] block1_o,
  output logic [15:0] block2_o,
  output logic [15:0] block3_o,
  output logic        busy_o,
  output logic        move_ok_o,
  output logic        move_rej_o,
  output logic [9:0]  move_count_o
);

  localparam logic [1:0]        LAST_IDX = 2'(NUM_BLOCKS - 1);
  localparam logic signed [9:0] STEP_S   = 10'(STEP);
  localparam logic signed [9:0] XMAX_S   = 10'(X_MAX);
  localparam logic signed [9:0] YMAX_S   = 10'(Y_MAX);
  localparam logic signed [9:0] LEN_S    = 10'(BLK_LEN);
  localparam logic signed [9:0] THK_S    = 10'(BLK_THK);

  state_e      state_q, state_d;
  op_e         op_q, op_d, req_op_s;
  logic [1:0]  sel_q, sel_d, scan_q, scan_d;
  logic        orient_q, orient_d;
  logic [15:0] cand_q, cand_d, cand_s, cur_s;
  logic        rej_q, rej_d;
  logic [15:0] blk_q [4];
  logic [15:0] blk_d [4];
  logic [9:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d, ok_q, ok_d, rejp_q, rejp_d;
  logic        req_s, legal_s, axis_ok_s, overlap_s, co_s;
  logic signed [9:0] cx_s, cy_s, w_s, h_s;

  block_move_controller_rect_overlap #(
    .BLK_LEN (BLK_LEN),
    .BLK_THK (BLK_THK)
  ) u_overlap (
    .a_word_i  (cand_q),
    .b_word_i  (blk_q[scan_q]),
    .overlap_o (overlap_s)
  );

  // Request decode with fixed priority: orient, left, right, up, down.
  always_comb begin
    req_s    = set_orient_i | move_left_i | move_right_i | move_up_i | move_down_i;
    req_op_s = OP_DOWN;
    if (set_orient_i)      req_op_s = OP_ORIENT;
    else if (move_left_i)  req_op_s = OP_LEFT;
    else if (move_right_i) req_op_s = OP_RIGHT;
    else if (move_up_i)    req_op_s = OP_UP;
    else                   req_op_s = OP_DOWN;
  end

  // Candidate word and legality (axis + bounds); signed so stepping below zero is caught.
  always_comb begin
    cur_s     = blk_q[sel_q];
    cx_s      = {2'b00, word_x(cur_s)};
    cy_s      = {3'b000, word_y(cur_s)};
    co_s      = cur_s[ORIENT_BIT];
    axis_ok_s = 1'b1;
    case (op_q)
      OP_ORIENT: co_s = orient_q;
      OP_LEFT:   begin cx_s = cx_s - STEP_S; axis_ok_s = ~cur_s[ORIENT_BIT]; end
      OP_RIGHT:  begin cx_s = cx_s + STEP_S; axis_ok_s = ~cur_s[ORIENT_BIT]; end
      OP_UP:     begin cy_s = cy_s - STEP_S; axis_ok_s = cur_s[ORIENT_BIT]; end
      OP_DOWN:   begin cy_s = cy_s + STEP_S; axis_ok_s = cur_s[ORIENT_BIT]; end
      default:   axis_ok_s = 1'b0;
    endcase
    w_s     = co_s ? THK_S : LEN_S;
    h_s     = co_s ? LEN_S : THK_S;
    legal_s = axis_ok_s && (cx_s >= 10'sd0) && (cx_s + w_s - 10'sd1 <= XMAX_S) &&
              (cy_s >= 10'sd0) && (cy_s + h_s - 10'sd1 <= YMAX_S);
    cand_s  = {cy_s[6:0], cx_s[7:0], co_s};
  end

  // Sequencer next-state and commit logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sel_d    = sel_q;
    orient_d = orient_q;
    cand_d   = cand_q;
    rej_d    = rej_q;
    scan_d   = scan_q;
    blk_d    = blk_q;
    cnt_d    = cnt_q;
    ok_d     = 1'b0;
    rejp_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          state_d  = ST_CALC;
          op_d     = req_op_s;
          sel_d    = sel_i;
          orient_d = orient_in_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        cand_d  = cand_s;
        rej_d   = ~legal_s;
        scan_d  = 2'd0;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        // The own index still burns its cycle so latency never varies.
        if (!rej_q && (scan_q != sel_q) && overlap_s) rej_d = 1'b1;
        else                                          rej_d = rej_q;
        if (scan_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          scan_d  = scan_q + 2'd1;
          state_d = ST_CHECK;
        end
      end
      ST_DONE: begin
        if (rej_q) begin
          rejp_d = 1'b1;
        end else begin
          blk_d[sel_q] = cand_q;
          ok_d         = 1'b1;
          if (cnt_q != 10'd1023) cnt_d = cnt_q + 10'd1;
          else                   cnt_d = cnt_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ORIENT;
      sel_q    <= 2'd0;
      orient_q <= 1'b0;
      cand_q   <= 16'h0000;
      rej_q    <= 1'b0;
      scan_q   <= 2'd0;
      blk_q[0] <= INIT0;
      blk_q[1] <= INIT1;
      blk_q[2] <= INIT2;
      blk_q[3] <= INIT3;
      cnt_q    <= 10'd0;
      busy_q   <= 1'b0;
      ok_q     <= 1'b0;
      rejp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sel_q    <= sel_d;
      orient_q <= orient_d;
      cand_q   <= cand_d;
      rej_q    <= rej_d;
      scan_q   <= scan_d;
      blk_q    <= blk_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ok_q     <= ok_d;
      rejp_q   <= rejp_d;
    end
  end

  assign block0_o     = blk_q[0];
  assign block1_o     = blk_q[1];
  assign block2_o     = blk_q[2];
  assign block3_o     = blk_q[3];
  assign busy_o       = busy_q;
  assign move_ok_o    = ok_q;
  assign move_rej_o   = rejp_q;
  assign move_count_o = cnt_q;

endmodule

// File: tb/tb_block_move_controller.sv
// Self-checking bench: directed vector table, corner sequences, and random requests against a geometric model.
module tb_block_move_controller;

  localparam int LEN = 16, THK = 8, XMAX = 159, YMAX = 119, STEP = 1, LAT = 6;
  localparam logic [15:0] I0 = 16'h2814;  // H (10,20)
  localparam logic [15:0] I1 = 16'h2037;  // V (27,16)
  localparam logic [15:0] I2 = 16'hC800;  // H (0,100)
  localparam logic [15:0] I3 = 16'h012D;  // V (150,0)

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [1:0] sel = 2'd0;
  logic orient_in = 1'b0, set_orient = 1'b0, move_left = 1'b0, move_right = 1'b0;
  logic move_up = 1'b0, move_down = 1'b0;
  logic [15:0] block0, block1, block2, block3;
  logic busy, move_ok, move_rej;
  logic [9:0] move_count;

  int vectors = 0;
  int miscompares = 0;

  int mx [4];
  int my [4];
  int mo [4];
  int mcount;

  block_move_controller #(
    .NUM_BLOCKS(4), .X_MAX(XMAX), .Y_MAX(YMAX), .BLK_LEN(LEN), .BLK_THK(THK), .STEP(STEP),
    .INIT0(I0), .INIT1(I1), .INIT2(I2), .INIT3(I3)
  ) dut (
    .clock_i(clk), .resetn_i(resetn), .sel_i(sel), .orient_in_i(orient_in),
    .set_orient_i(set_orient), .move_left_i(move_left), .move_right_i(move_right),
    .move_up_i(move_up), .move_down_i(move_down),
    .block0_o(block0), .block1_o(block1), .block2_o(block2), .block3_o(block3),
    .busy_o(busy), .move_ok_o(move_ok), .move_rej_o(move_rej), .move_count_o(move_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] blk(input int i);
    case (i)
      0: return block0;
      1: return block1;
      2: return block2;
      default: return block3;
    endcase
  endfunction

  function automatic logic [15:0] mword(input int i);
    return 16'((my[i] << 9) | (mx[i] << 1) | mo[i]);
  endfunction

  task automatic model_reset();
    logic [15:0] w [4];
    w[0] = I0; w[1] = I1; w[2] = I2; w[3] = I3;
    for (int i = 0; i < 4; i++) begin
      mo[i] = int'(w[i][0]);
      mx[i] = int'(w[i][8:1]);
      my[i] = int'(w[i][15:9]);
    end
    mcount = 0;
  endtask

  // Geometric reference: returns 0 no request, 1 commit, 2 reject. p = {down,up,right,left,orient}.
  function automatic int model_req(input int s, input bit oi, input bit [4:0] p);
    int nx, ny, no, w, h, bw, bh;
    bit legal;
    nx = mx[s]; ny = my[s]; no = mo[s]; legal = 1'b1;
    if (p[0])      no = int'(oi);
    else if (p[1]) begin nx = nx - STEP; legal = (mo[s] == 0); end
    else if (p[2]) begin nx = nx + STEP; legal = (mo[s] == 0); end
    else if (p[3]) begin ny = ny - STEP; legal = (mo[s] == 1); end
    else if (p[4]) begin ny = ny + STEP; legal = (mo[s] == 1); end
    else return 0;
    w = (no != 0) ? THK : LEN;
    h = (no != 0) ? LEN : THK;
    if (nx < 0 || nx + w - 1 > XMAX || ny < 0 || ny + h - 1 > YMAX) legal = 1'b0;
    for (int j = 0; j < 4; j++) begin
      bw = (mo[j] != 0) ? THK : LEN;
      bh = (mo[j] != 0) ? LEN : THK;
      if (legal && j != s && nx < mx[j] + bw && mx[j] < nx + w && ny < my[j] + bh && my[j] < ny + h)
        legal = 1'b0;
    end
    if (legal) begin
      mx[s] = nx; my[s] = ny; mo[s] = no;
      if (mcount < 1023) mcount++;
      return 1;
    end
    return 2;
  endfunction

  // Drive one request from #1 after an edge; returns 1 ok, 2 rej, 3 both, 0 timeout.
  task automatic do_req(input logic [1:0] s, input logic oi, input logic [4:0] p, output int res);
    int first;
    sel = s; orient_in = oi;
    {move_down, move_up, move_right, move_left, set_orient} = p;
    @(posedge clk); #1;
    {move_down, move_up, move_right, move_left, set_orient} = 5'b00000;
    check("busy_after_sample", busy, 1);
    first = 0;
    for (int k = 1; k <= LAT + 2 && first == 0; k++) begin
      @(posedge clk); #1;
      if (move_ok || move_rej) first = k;
    end
    check("pulse_latency", first, LAT);
    check("busy_cleared", busy, 0);
    res = (move_ok && move_rej) ? 3 : (move_ok ? 1 : (move_rej ? 2 : 0));
  endtask

  task automatic check_all_vs_model(input string tag);
    for (int i = 0; i < 4; i++) check({tag, "_block"}, blk(i), mword(i));
    check({tag, "_count"}, move_count, mcount);
  endtask

  typedef struct {
    logic [1:0]  s;
    logic        oi;
    logic [4:0]  p;
    int          exp_res;
    logic [15:0] exp_word;
    int          exp_cnt;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int res, mres, quiet;
    logic [1:0] rs;
    logic ro;
    logic [4:0] rp;

    tbl[0]  = '{2'd0, 1'b0, 5'b00100, 1, 16'h2816, 1};  // right to x=11, touches block1
    tbl[1]  = '{2'd0, 1'b0, 5'b00100, 2, 16'h2816, 1};  // x=12 overlaps block1
    tbl[2]  = '{2'd0, 1'b0, 5'b00110, 1, 16'h2814, 2};  // left beats right
    tbl[3]  = '{2'd2, 1'b0, 5'b00010, 2, 16'hC800, 2};  // x=0 left
    tbl[4]  = '{2'd3, 1'b0, 5'b00010, 2, 16'h012D, 2};  // vertical cannot move left
    tbl[5]  = '{2'd3, 1'b0, 5'b01000, 2, 16'h012D, 2};  // y=0 up
    tbl[6]  = '{2'd3, 1'b0, 5'b10000, 1, 16'h032D, 3};  // down to y=1
    tbl[7]  = '{2'd1, 1'b1, 5'b00001, 1, 16'h2037, 4};  // same-orientation no-op
    tbl[8]  = '{2'd0, 1'b1, 5'b00001, 1, 16'h2815, 5};  // block0 to vertical
    tbl[9]  = '{2'd0, 1'b1, 5'b10001, 1, 16'h2815, 6};  // orient beats down
    tbl[10] = '{2'd0, 1'b0, 5'b01000, 1, 16'h2615, 7};  // up to y=19
    tbl[11] = '{2'd2, 1'b0, 5'b00100, 1, 16'hC802, 8};  // right to x=1
    tbl[12] = '{2'd3, 1'b0, 5'b00001, 2, 16'h032D, 8};  // far edge 165 out of range

    @(posedge clk); #1;
    resetn = 1'b1;
    model_reset();
    check("reset_block0", block0, I0);
    check("reset_block1", block1, I1);
    check("reset_block2", block2, I2);
    check("reset_block3", block3, I3);
    check("reset_count", move_count, 0);
    check("reset_busy", busy, 0);
    check("reset_pulses", {move_ok, move_rej}, 0);

    for (int v = 0; v < 13; v++) begin
      do_req(tbl[v].s, tbl[v].oi, tbl[v].p, res);
      mres = model_req(int'(tbl[v].s), tbl[v].oi, tbl[v].p);
      check($sformatf("tbl%0d_result", v), res, tbl[v].exp_res);
      check($sformatf("tbl%0d_word", v), blk(int'(tbl[v].s)), tbl[v].exp_word);
      check($sformatf("tbl%0d_count", v), move_count, tbl[v].exp_cnt);
      check($sformatf("tbl%0d_model", v), mres, tbl[v].exp_res);
    end

    // Pulse arriving while busy must be dropped.
    sel = 2'd0; move_down = 1'b1;
    @(posedge clk); #1; move_down = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1;
    sel = 2'd2; move_right = 1'b1;
    @(posedge clk); #1; move_right = 1'b0;
    mres = model_req(0, 1'b0, 5'b10000);
    quiet = 0;
    for (int k = 0; k < 3 * LAT; k++) begin
      if (move_ok || move_rej) quiet++;
      @(posedge clk); #1;
    end
    check("busy_ignore_pulses", quiet, 1);
    check_all_vs_model("busy_ignore");

    // Reset during the collision scan aborts the request.
    sel = 2'd0; move_up = 1'b1;
    @(posedge clk); #1; move_up = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1; @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    model_reset();
    quiet = 0;
    for (int k = 0; k < 2 * LAT; k++) begin
      if (move_ok || move_rej || busy) quiet++;
      @(posedge clk); #1;
    end
    check("abort_quiet", quiet, 0);
    check_all_vs_model("abort");

    // Random requests against the model.
    for (int n = 0; n < 300; n++) begin
      rs = 2'($urandom_range(0, 3));
      ro = 1'($urandom_range(0, 1));
      rp = 5'($urandom_range(1, 31));
      do_req(rs, ro, rp, res);
      mres = model_req(int'(rs), ro, rp);
      check("rand_result", res, mres);
      check_all_vs_model("rand");
    end

    // Saturation of the accepted-move counter.
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    model_reset();
    for (int n = 0; n < 1024; n++) begin
      do_req(2'd1, 1'b1, 5'b00001, res);
      mres = model_req(1, 1'b1, 5'b00001);
      if (n == 1022) check("count_at_1023", move_count, 1023);
    end
    check("sat_last_result", res, 1);
    check("count_saturated", move_count, 1023);
    check("sat_model_count", move_count, mcount);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
